regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two requesters: the pipeline writeback stage (wb) and the multi-cycle multdiv unit (md).
- Drives the write-port controls (enable, 5-bit register select, data). The 5-to-32 write decoder and the register array consume these directly.
- Holds colliding md results in a small FIFO.
- Keeps a per-register busy scoreboard so decode can detect hazards on md destinations.
- Suppresses md writes made stale by a younger wb write.

Parameters:
- DATA_W, 32, write data width.
- ADDR_W, 5, register select width.
- NREG, 32, number of registers; must equal 2**ADDR_W.
- BUF_DEPTH, 2, md result FIFO depth (power of 2, >=1).

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- wb_valid  in  1  pipeline writeback request this cycle.
- wb_reg  in  ADDR_W  writeback destination.
- wb_data  in  DATA_W  writeback data.
- md_issue  in  1  multdiv operation issued this cycle.
- md_issue_reg  in  ADDR_W  destination of the issued md op.
- md_valid  in  1  md result available; one-cycle pulse.
- md_reg  in  ADDR_W  destination tag of the md result.
- md_data  in  DATA_W  md result data.
- md_ready  out  1  FIFO not full; md results accepted.
- ctrl_writeEnable  out  1  registered write enable to the register file.
- ctrl_writeReg  out  ADDR_W  registered write select (feeds decoder).
- data_writeReg  out  DATA_W  registered write data.
- busy  out  NREG  scoreboard; bit r=1 means an md write to r is outstanding.
- err_overflow  out  1  sticky; md_valid seen while md_ready=0.

Behaviour:
- Reset (clock edge with reset=1) clears:
  - all outputs (ctrl_writeEnable=0, ctrl_writeReg=0, data_writeReg=0, busy=0, err_overflow=0);
  - the FIFO (empty) and the stale vector.
  - md_ready=1 after reset.
  - Reset mid-operation discards buffered md results without writing them.
- Grant per cycle, fixed priority:
  1. wb_valid: wb wins. A simultaneous md_valid is pushed into the FIFO.
  2. Else if FIFO non-empty: pop head. A simultaneous md_valid is pushed (push and pop in the same cycle allowed, even when full).
  3. Else if md_valid: md result granted directly (bypass, no FIFO entry).
  4. Else: no grant.
- Latency: the grant in cycle N appears on ctrl_writeEnable/ctrl_writeReg/data_writeReg after the edge ending cycle N (1 cycle). With no grant, ctrl_writeEnable=0 and ctrl_writeReg/data_writeReg hold their last values.
- Register 0:
  - any granted write to reg 0 yields ctrl_writeEnable=0;
  - md_issue to reg 0 does not set busy[0]; busy[0] is always 0.
- Scoreboard:
  - md_issue sets busy[md_issue_reg] and clears stale[md_issue_reg].
  - When an md result for r is granted (FIFO pop or bypass), busy[r] and stale[r] clear at the same edge as the output register loads.
  - If issue and clear hit the same r in one cycle, the set wins.
- Stale suppression (WAW):
  - a granted wb write to r while busy[r]=1 sets stale[r];
  - when the md result for r is later granted and stale[r]=1, ctrl_writeEnable=0 for that grant, but busy[r] and stale[r] still clear.
- FIFO:
  - md_ready = (count < BUF_DEPTH), or count==BUF_DEPTH with a pop this cycle, i.e. !wb_valid. md_ready is combinational.
  - md_valid with md_ready=0: result dropped, err_overflow set, busy unchanged.
  - Pointers wrap modulo BUF_DEPTH.
  - Order preserved: FIFO results always write before a later md_valid.
- Only one md op is in flight per destination. Tags are taken from md_reg, not recomputed.

Test Plan:
- Reset: hold reset 2 cycles with wb_valid=1 -> all outputs 0, md_ready=1, no write enable.
- wb only: wb_valid=1, wb_reg=5, wb_data=0xDEADBEEF in cycle N -> cycle N+1: ctrl_writeEnable=1, ctrl_writeReg=5, data_writeReg=0xDEADBEEF; cycle N+2 enable=0.
- Collision and drain:
  - setup: md_issue reg 7 earlier; then wb (reg 3, 0x11) and md_valid (reg 7, 0x22) in the same cycle N.
  - N+1: write reg 3 = 0x11, busy[7]=1.
  - N+2: write reg 7 = 0x22, busy[7]=0.
- Overflow:
  - stimulus: wb_valid held high, 3 md results on consecutive cycles, BUF_DEPTH=2.
  - third result: md_ready=0, dropped, err_overflow=1 sticky.
  - after wb drops: the two buffered results write in arrival order.
- Stale WAW:
  - md_issue reg 9, then wb write reg 9 = 0xAA, then md_valid reg 9 = 0xBB.
  - reg 9 write of 0xAA occurs; the md grant cycle has ctrl_writeEnable=0; busy[9] clears.
- Reg 0 and same-cycle set/clear:
  - md_issue reg 0 -> busy[0] stays 0, and the md result to reg 0 gives enable=0.
  - md_valid reg 4 granted with md_issue reg 4 in the same cycle -> busy[4] remains 1.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// Write-port arbiter for the register file: wb has priority, md results are
// buffered on collision, and a per-register scoreboard tracks outstanding md writes.
module regfile_write_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 5,
    parameter int unsigned NREG      = 32,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wb_valid,
    input  logic [ADDR_W-1:0] wb_reg,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              md_issue,
    input  logic [ADDR_W-1:0] md_issue_reg,
    input  logic              md_valid,
    input  logic [ADDR_W-1:0] md_reg,
    input  logic [DATA_W-1:0] md_data,
    output logic              md_ready,
    output logic              ctrl_writeEnable,
    output logic [ADDR_W-1:0] ctrl_writeReg,
    output logic [DATA_W-1:0] data_writeReg,
    output logic [NREG-1:0]   busy,
    output logic              err_overflow
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] tag;
        logic [DATA_W-1:0] data;
    } md_entry_t;

    md_entry_t         mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [NREG-1:0]   busy_q, busy_d, stale_q, stale_d;
    logic              err_q, err_d, we_q, we_d;
    logic [ADDR_W-1:0] wreg_q, wreg_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              fifo_empty, fifo_full, pop, push, bypass;
    md_entry_t         grant_entry, in_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Grant selection, FIFO bookkeeping and scoreboard update
    always_comb begin
        fifo_empty  = (count_q == '0);
        fifo_full   = (count_q == CNT_W'(BUF_DEPTH));
        pop         = !wb_valid && !fifo_empty;
        md_ready    = !fifo_full || pop;
        bypass      = md_valid && !wb_valid && fifo_empty;
        push        = md_valid && md_ready && !bypass;
        in_entry    = '{tag: md_reg, data: md_data};
        grant_entry = pop ? mem_q[rd_ptr_q] : in_entry;

        we_d     = 1'b0;
        wreg_d   = wreg_q;
        wdata_d  = wdata_q;
        busy_d   = busy_q;
        stale_d  = stale_q;
        err_d    = err_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        if (wb_valid) begin
            we_d    = (wb_reg != '0);
            wreg_d  = wb_reg;
            wdata_d = wb_data;
            if (busy_q[wb_reg]) stale_d[wb_reg] = 1'b1;
        end else if (pop || bypass) begin
            // A younger wb write already landed: drop the md data but retire the tag
            we_d    = (grant_entry.tag != '0) && !stale_q[grant_entry.tag];
            wreg_d  = grant_entry.tag;
            wdata_d = grant_entry.data;
            busy_d[grant_entry.tag]  = 1'b0;
            stale_d[grant_entry.tag] = 1'b0;
        end

        if (md_issue) begin
            stale_d[md_issue_reg] = 1'b0;
            if (md_issue_reg != '0) busy_d[md_issue_reg] = 1'b1;
        end

        if (md_valid && !md_ready) err_d = 1'b1;
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            we_q     <= 1'b0;
            wreg_q   <= '0;
            wdata_q  <= '0;
            busy_q   <= '0;
            stale_q  <= '0;
            err_q    <= 1'b0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            we_q     <= we_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            busy_q   <= busy_d;
            stale_q  <= stale_d;
            err_q    <= err_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; validity is tracked by count_q
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= in_entry;
    end

    assign ctrl_writeEnable = we_q;
    assign ctrl_writeReg    = wreg_q;
    assign data_writeReg    = wdata_q;
    assign busy             = busy_q;
    assign err_overflow     = err_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed scenarios plus random traffic against a queue-based reference model.
module tb_regfile_write_arbiter;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        wb_valid, md_issue, md_valid;
    logic [4:0]  wb_reg, md_issue_reg, md_reg;
    logic [31:0] wb_data, md_data;
    logic        md_ready, ctrl_writeEnable, err_overflow;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg, busy;

    regfile_write_arbiter #(.DATA_W(32), .ADDR_W(5), .NREG(32), .BUF_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .md_issue(md_issue), .md_issue_reg(md_issue_reg),
        .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data),
        .md_ready(md_ready), .ctrl_writeEnable(ctrl_writeEnable),
        .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
        .busy(busy), .err_overflow(err_overflow)
    );

    initial forever #5 clock = ~clock;

    typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
    ent_t        m_q[$];
    logic [31:0] m_busy, m_stale, m_wdata;
    logic        m_err, m_we;
    logic [4:0]  m_wreg;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic m_ready();
        return (m_q.size() < DEPTH) || (!wb_valid && m_q.size() > 0);
    endfunction

    task automatic m_md_grant(input logic [4:0] r, input logic [31:0] d);
        m_we       = (r != 0) && !m_stale[r];
        m_wreg     = r;
        m_wdata    = d;
        m_busy[r]  = 1'b0;
        m_stale[r] = 1'b0;
    endtask

    task automatic model_update();
        ent_t e;
        logic rdy;
        if (reset) begin
            m_q.delete();
            m_busy = 0; m_stale = 0; m_err = 0; m_we = 0; m_wreg = 0; m_wdata = 0;
            return;
        end
        rdy = m_ready();
        e.r = md_reg;
        e.d = md_data;
        if (md_valid && !rdy) m_err = 1'b1;
        if (wb_valid) begin
            m_we = (wb_reg != 0); m_wreg = wb_reg; m_wdata = wb_data;
            if (m_busy[wb_reg]) m_stale[wb_reg] = 1'b1;
            if (md_valid && rdy) m_q.push_back(e);
        end else if (m_q.size() > 0) begin
            ent_t h;
            h = m_q.pop_front();
            if (md_valid) m_q.push_back(e);
            m_md_grant(h.r, h.d);
        end else if (md_valid) begin
            m_md_grant(md_reg, md_data);
        end else begin
            m_we = 1'b0;
        end
        if (md_issue) begin
            m_stale[md_issue_reg] = 1'b0;
            if (md_issue_reg != 0) m_busy[md_issue_reg] = 1'b1;
        end
    endtask

    // One cycle: check md_ready before the edge, advance model, check registered outputs after
    task automatic step();
        logic exp_rdy;
        exp_rdy = m_ready();
        #1;
        if (!reset) chk("md_ready", md_ready, exp_rdy);
        @(posedge clock);
        model_update();
        #1;
        chk("we", ctrl_writeEnable, m_we);
        chk("wreg", ctrl_writeReg, m_wreg);
        chk("wdata", data_writeReg, m_wdata);
        chk("busy", busy, m_busy);
        chk("err", err_overflow, m_err);
    endtask

    task automatic drive(input logic wv, input logic [4:0] wr, input logic [31:0] wd,
                         input logic mi, input logic [4:0] mir,
                         input logic mv, input logic [4:0] mr, input logic [31:0] mdd);
        wb_valid = wv; wb_reg = wr; wb_data = wd;
        md_issue = mi; md_issue_reg = mir;
        md_valid = mv; md_reg = mr; md_data = mdd;
        step();
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        drive(1, 5, 32'h1234, 0, 0, 0, 0, 0);
        drive(1, 6, 32'h5678, 0, 0, 1, 2, 32'h9);
        chk("rst_we", ctrl_writeEnable, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;
        idle();
        chk("rst_ready", md_ready, 1);

        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        chk("wb_reg5", ctrl_writeReg, 5);
        chk("wb_data5", data_writeReg, 32'hDEADBEEF);
        idle();
        chk("wb_off", ctrl_writeEnable, 0);

        drive(0, 0, 0, 1, 7, 0, 0, 0);
        drive(1, 3, 32'h11, 0, 0, 1, 7, 32'h22);
        chk("col_busy7", busy[7], 1);
        idle();
        chk("drain_reg7", ctrl_writeReg, 7);
        chk("drain_busy7", busy[7], 0);

        drive(0, 0, 0, 1, 10, 0, 0, 0);
        drive(0, 0, 0, 1, 11, 0, 0, 0);
        drive(0, 0, 0, 1, 12, 0, 0, 0);
        drive(1, 1, 32'h1, 0, 0, 1, 10, 32'hA0);
        drive(1, 2, 32'h2, 0, 0, 1, 11, 32'hB0);
        drive(1, 3, 32'h3, 0, 0, 1, 12, 32'hC0);
        chk("ovf_err", err_overflow, 1);
        idle();
        chk("ovf_first", data_writeReg, 32'hA0);
        idle();
        chk("ovf_second", data_writeReg, 32'hB0);
        chk("ovf_sticky", err_overflow, 1);

        drive(0, 0, 0, 1, 9, 0, 0, 0);
        drive(1, 9, 32'hAA, 0, 0, 0, 0, 0);
        chk("waw_wb", data_writeReg, 32'hAA);
        drive(0, 0, 0, 0, 0, 1, 9, 32'hBB);
        chk("waw_we", ctrl_writeEnable, 0);
        chk("waw_busy9", busy[9], 0);

        drive(0, 0, 0, 1, 0, 0, 0, 0);
        chk("r0_busy", busy[0], 0);
        drive(0, 0, 0, 0, 0, 1, 0, 32'h77);
        chk("r0_we", ctrl_writeEnable, 0);
        drive(0, 0, 0, 1, 4, 0, 0, 0);
        drive(0, 0, 0, 1, 4, 1, 4, 32'h44);
        chk("setwins_busy4", busy[4], 1);

        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)),
                  $urandom_range(0, 4) < 2, 5'($urandom_range(0, 7)), $urandom);
        end
        reset = 1'b0;
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
